// File: rtl/neuron_serial_driver_pkg.sv
// Shared definitions for the bit-serial neuron driver.
// Contents: FSM state encoding, ALU opcode constants and the default accumulator width.
package neuron_serial_driver_pkg;

    // Must match the ALU datapath width.
    localparam int unsigned DefaultAccW = 12;

    localparam logic AluOpAdd1 = 1'b0;
    localparam logic AluOpSub1 = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/neuron_serial_driver_if.sv
// Job/result handshake bundle for the neuron serial driver.
//   in_valid/in_ready : job request handshake carrying in_act, in_wgt, in_init
//   out_valid/out_ready : result handshake carrying out_acc (raw signed accumulator)
// Modports: slave = driver side, master = job producer / result consumer side.
interface neuron_serial_driver_if #(
    parameter int unsigned NIn  = 16,
    parameter int unsigned AccW = 12
) ();

    logic            in_valid;
    logic            in_ready;
    logic [NIn-1:0]  in_act;
    logic [NIn-1:0]  in_wgt;
    logic [AccW-1:0] in_init;
    logic            out_valid;
    logic            out_ready;
    logic [AccW-1:0] out_acc;

    modport slave (
        input  in_valid, in_act, in_wgt, in_init, out_ready,
        output in_ready, out_valid, out_acc
    );

    modport master (
        output in_valid, in_act, in_wgt, in_init, out_ready,
        input  in_ready, out_valid, out_acc
    );

endinterface

// File: rtl/neuron_serial_driver_bit_serializer.sv
// Holds the activation and weight-sign shift registers plus the step counter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : capture act_i/wgt_i and clear the counter
//   shift_i       : shift both registers right (zero fill) and count one step
//   act_lsb_o, wgt_lsb_o : current serial bits
//   last_o        : counter is on the final step (NIn-1)
module neuron_serial_driver_bit_serializer #(
    parameter int unsigned NIn = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic [NIn-1:0] act_i,
    input  logic [NIn-1:0] wgt_i,
    output logic           act_lsb_o,
    output logic           wgt_lsb_o,
    output logic           last_o
);

    localparam int unsigned CntW = $clog2(NIn);

    logic [NIn-1:0]  act_q;
    logic [NIn-1:0]  wgt_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            act_q <= '0;
            wgt_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            act_q <= act_i;
            wgt_q <= wgt_i;
            cnt_q <= '0;
        end else if (shift_i) begin
            act_q <= {1'b0, act_q[NIn-1:1]};
            wgt_q <= {1'b0, wgt_q[NIn-1:1]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign act_lsb_o = act_q[0];
    assign wgt_lsb_o = wgt_q[0];
    assign last_o    = (cnt_q == CntW'(NIn - 1));

endmodule

// File: rtl/neuron_serial_driver.sv
// Sequencer for the bit-serial neuron ALU. Takes one job (activations, weight signs,
// initial accumulator), feeds one bit pair per cycle LSB-first to the ALU while looping
// the ALU result back through acc_q, then offers the raw accumulator on a valid/ready port.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   bus_io             : job/result handshake bundle (slave modport)
//   alu_in_a_lsb_o     : activation bit to the ALU (0 outside RUN)
//   alu_op_o           : ALU opcode, 0 add / 1 sub (0 outside RUN)
//   alu_in_b_o         : accumulator to the ALU
//   alu_out_i          : ALU result
// Optional build macro NEURON_SAT_EN: hold acc_q at max positive instead of wrapping.
module neuron_serial_driver
    import neuron_serial_driver_pkg::*;
#(
    parameter int unsigned NIn  = 16,
    parameter int unsigned AccW = DefaultAccW
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    neuron_serial_driver_if.slave  bus_io,
    output logic                   alu_in_a_lsb_o,
    output logic                   alu_op_o,
    output logic [AccW-1:0]        alu_in_b_o,
    input  logic [AccW-1:0]        alu_out_i
);

    state_e          state_q;
    logic [AccW-1:0] acc_q;
    logic [AccW-1:0] acc_d;
    logic            in_ready_q;
    logic            out_valid_q;

    logic load;
    logic shift;
    logic act_lsb;
    logic wgt_lsb;
    logic last;

    assign load  = (state_q == StIdle) && bus_io.in_valid && in_ready_q;
    assign shift = (state_q == StRun);

    neuron_serial_driver_bit_serializer #(
        .NIn (NIn)
    ) u_serializer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .shift_i   (shift),
        .act_i     (bus_io.in_act),
        .wgt_i     (bus_io.in_wgt),
        .act_lsb_o (act_lsb),
        .wgt_lsb_o (wgt_lsb),
        .last_o    (last)
    );

    always_comb begin
        acc_d = alu_out_i;
`ifdef NEURON_SAT_EN
        // Adding one to max positive would wrap negative; pin it instead.
        if (acc_q == {1'b0, {(AccW-1){1'b1}}} && wgt_lsb == AluOpAdd1 && act_lsb) begin
            acc_d = acc_q;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        acc_q      <= bus_io.in_init;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    if (last) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign alu_in_a_lsb_o   = shift ? act_lsb : 1'b0;
    assign alu_op_o         = shift ? wgt_lsb : AluOpAdd1;
    assign alu_in_b_o       = acc_q;
    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_acc   = acc_q;

endmodule

// File: tb/tb_neuron_serial_driver.sv
// Bench for neuron_serial_driver with a behavioural stand-in for the neuron ALU.
module tb_neuron_serial_driver;

    localparam int unsigned NIn  = 4;
    localparam int unsigned AccW = 12;
    localparam int          Half = 2 ** (AccW - 1);
    localparam int          Full = 2 ** AccW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_serial_driver_if #(.NIn(NIn), .AccW(AccW)) bus ();

    logic            alu_a;
    logic            alu_op;
    logic [AccW-1:0] alu_b;
    logic [AccW-1:0] alu_out;
    logic [AccW-1:0] alu_b_cl;

    // ALU: clamp negative input to zero, then add/subtract the activation bit (wraps).
    assign alu_b_cl = alu_b[AccW-1] ? '0 : alu_b;
    assign alu_out  = alu_b_cl + (alu_a ? (alu_op ? {AccW{1'b1}} : AccW'(1)) : '0);

    neuron_serial_driver #(.NIn(NIn), .AccW(AccW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus_io         (bus),
        .alu_in_a_lsb_o (alu_a),
        .alu_op_o       (alu_op),
        .alu_in_b_o     (alu_b),
        .alu_out_i      (alu_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: one serial step on a signed accumulator value.
    function automatic int ref_step(input int acc, input bit a, input bit w);
        int b;
        int r;
`ifdef NEURON_SAT_EN
        if (acc == Half - 1 && a && !w) return acc;
`endif
        b = (acc < 0) ? 0 : acc;
        r = b + (a ? (w ? -1 : 1) : 0);
        return ((r + Half) % Full + Full) % Full - Half;
    endfunction

    function automatic logic [31:0] sx(input logic [AccW-1:0] v);
        return 32'($signed(v));
    endfunction

    task automatic run_job(input string tag, input logic [NIn-1:0] act,
                           input logic [NIn-1:0] wgt, input int init, input int hold);
        int acc;
        int k;
        acc = init;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, " ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_act   = act;
        bus.in_wgt   = wgt;
        bus.in_init  = AccW'(init);
        @(posedge clk); #1;
        // Inputs need not be held after the handshake.
        bus.in_valid = 1'b0;
        bus.in_act   = NIn'($urandom);
        bus.in_wgt   = NIn'($urandom);
        bus.in_init  = AccW'($urandom);
        k = 0;
        while (!bus.out_valid && k < 3 * NIn) begin
            if (k < NIn) begin
                check({tag, " a_lsb"}, 32'(alu_a), 32'(act[k]));
                check({tag, " op"}, 32'(alu_op), 32'(wgt[k]));
                check({tag, " in_b"}, sx(alu_b), acc);
                check({tag, " busy"}, 32'(bus.in_ready), 32'd0);
                acc = ref_step(acc, act[k], wgt[k]);
            end
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, k, NIn);
        check({tag, " out_acc"}, sx(bus.out_acc), acc);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_act   = NIn'($urandom);
            bus.in_init  = AccW'($urandom);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold acc"}, sx(bus.out_acc), acc);
            check({tag, " hold ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " drop valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " idle ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, " idle pins"}, {30'd0, alu_a, alu_op}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.in_init   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset acc", sx(bus.out_acc), 32'd0);
        check("reset pins", {30'd0, alu_a, alu_op}, 32'd0);

        run_job("count up", 4'b1111, 4'b0000, 0, 0);
        check("count up value", sx(bus.out_acc), 32'd4);
        run_job("clamp sub", 4'b1111, 4'b1111, 0, 0);
        check("clamp sub value", sx(bus.out_acc), 32'hFFFF_FFFF);
        run_job("mixed", 4'b1010, 4'b0010, 5, 0);
        check("mixed value", sx(bus.out_acc), 32'd5);
        run_job("wrap", 4'b0001, 4'b0000, Half - 1, 0);
`ifdef NEURON_SAT_EN
        check("wrap value", sx(bus.out_acc), 32'(Half - 1));
`else
        check("wrap value", sx(bus.out_acc), 32'd0);
`endif
        run_job("stall", 4'b0110, 4'b0100, 100, 10);

        // Reset during RUN aborts the job.
        bus.in_valid = 1'b1;
        bus.in_act   = 4'b1111;
        bus.in_wgt   = 4'b0000;
        bus.in_init  = AccW'(77);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort acc", sx(bus.out_acc), 32'd0);
        check("abort pins", {30'd0, alu_a, alu_op}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (NIn + 3) begin
                @(posedge clk); #1;
                seen = seen | bus.out_valid;
            end
            check("abort no pulse", 32'(seen), 32'd0);
        end
        run_job("after abort", 4'b1011, 4'b0001, -3, 1);

        for (int j = 0; j < 20; j++) begin
            int init;
            init = (j % 5 == 0) ? Half - 1 - j % 2 : int'($urandom_range(0, Full - 1)) - Half;
            run_job("random", NIn'($urandom), NIn'($urandom), init, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
